occ_cache_server: RTL and testbench

Serves Occ lookups for the accelerator core. It sits directly upstream of the core's rom_Occ port, receiving ce_rom_Occ/addr_rom_Occ and returning data_Occ/data_Occ_valid. A small direct-mapped cache absorbs repeated Occ indices. Misses go out to a variable-latency backing memory through a req/valid port.

---
 rtl/occ_cache_server.sv | 172 +++++++++++++++++
 tb/tb_occ_cache_server.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/occ_cache_server.sv
// occ_cache_server
//   Serves Occ lookups for the accelerator core through a small direct-mapped
//   cache. Misses are fetched from a variable-latency backing memory using a
//   one-cycle read strobe and a one-cycle data-valid return.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               one-cycle pulse, invalidates every cache line
//   ce_rom_Occ_i        lookup request, held with addr_rom_Occ_i until valid
//   addr_rom_Occ_i      Occ address
//   data_Occ_o          returned Occ word, holds between responses
//   data_Occ_valid_o    one-cycle pulse, data_Occ_o is valid
//   mem_re_o            backing-memory read strobe, one cycle per miss
//   mem_addr_o          backing-memory address, holds when mem_re_o is low
//   mem_data_i          backing-memory read data
//   mem_valid_i         backing-memory data valid pulse
//   busy_o              FSM not in IDLE
//   hit_cnt_o           saturating hit counter
//   miss_cnt_o          saturating miss counter
//
// state     | meaning
// IDLE      | waiting for ce; hit/miss decided here
// MISS_REQ  | one-cycle read strobe to backing memory
// MISS_WAIT | waiting for mem_valid_i, then fill the line
// RESP      | data_Occ_valid_o pulse; deferred flush applied on exit
module occ_cache_server #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ce_rom_Occ_i,
  input  logic [ADDR_W-1:0] addr_rom_Occ_i,
  output logic [DATA_W-1:0] data_Occ_o,
  output logic              data_Occ_valid_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_valid_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                flush_pending_q, flush_pending_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [DATA_W-1:0]   cache_data_q [LINES];
  logic [TAG_W-1:0]    cache_tag_q  [LINES];

  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic                lk_hit;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                fill_we;

  assign lk_idx   = addr_rom_Occ_i[IDX_W-1:0];
  assign lk_tag   = addr_rom_Occ_i[ADDR_W-1:IDX_W];
  // A flush in the same cycle as a request forces a miss.
  assign lk_hit   = valid_q[lk_idx] && (cache_tag_q[lk_idx] == lk_tag) && !flush;
  assign fill_idx = addr_q[IDX_W-1:0];
  assign fill_tag = addr_q[ADDR_W-1:IDX_W];

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    mem_addr_d      = mem_addr_q;
    valid_d         = valid_q;
    flush_pending_d = flush_pending_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    fill_we         = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) valid_d = '0;
        if (ce_rom_Occ_i) begin
          addr_d = addr_rom_Occ_i;
          if (lk_hit) begin
            data_d = cache_data_q[lk_idx];
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            state_d = RESP;
          end else begin
            mem_addr_d = addr_rom_Occ_i;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            state_d = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        if (flush) flush_pending_d = 1'b1;
        state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (flush) flush_pending_d = 1'b1;
        if (mem_valid_i) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          data_d            = mem_data_i;
          state_d           = RESP;
        end
      end
      RESP: begin
        // A flush seen while busy (including this cycle) lands as we leave.
        if (flush_pending_q || flush) valid_d = '0;
        flush_pending_d = 1'b0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      data_q          <= '0;
      mem_addr_q      <= '0;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      mem_addr_q      <= mem_addr_d;
      valid_q         <= valid_d;
      flush_pending_q <= flush_pending_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
    end
  end

  // Line storage carries no reset; valid_q alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      cache_data_q[fill_idx] <= mem_data_i;
      cache_tag_q[fill_idx]  <= fill_tag;
    end
  end

  assign data_Occ_o       = data_q;
  assign data_Occ_valid_o = (state_q == RESP);
  assign mem_re_o         = (state_q == MISS_REQ);
  assign mem_addr_o       = mem_addr_q;
  assign busy_o           = (state_q != IDLE);
  assign hit_cnt_o        = hit_cnt_q;
  assign miss_cnt_o       = miss_cnt_q;

endmodule

// File: tb/tb_occ_cache_server.sv
module tb_occ_cache_server;

  localparam int CW     = 4;   // narrow counters so saturation is reachable
  localparam int CMAX   = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        ce;
  logic [7:0]  addr;
  logic [31:0] data_o;
  logic        valid_o;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic        busy;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  occ_cache_server #(.ADDR_W(8), .DATA_W(32), .IDX_W(3), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .ce_rom_Occ_i     (ce),
    .addr_rom_Occ_i   (addr),
    .data_Occ_o       (data_o),
    .data_Occ_valid_o (valid_o),
    .mem_re_o         (mem_re),
    .mem_addr_o       (mem_addr),
    .mem_data_i       (mem_data),
    .mem_valid_i      (mem_valid),
    .busy_o           (busy),
    .hit_cnt_o        (hit_cnt),
    .miss_cnt_o       (miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference cache: plain arrays indexed by addr[2:0], tag addr[7:3].
  bit          ref_v    [8];
  logic [4:0]  ref_tag  [8];
  logic [31:0] ref_data [8];
  int          ref_hits;
  int          ref_misses;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] md;
    int          lat;
    bit          fa;     // flush together with the request
    bit          fb;     // flush while waiting on memory
    bit          hit;
    logic [31:0] data;
    int          hits;
    int          misses;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_v[i] = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] a, input logic [31:0] md, input int lat,
                        input bit fa, input bit fb, input bit use_tbl,
                        input bit t_hit, input logic [31:0] t_data,
                        input int t_hits, input int t_misses);
    bit m_hit;
    logic [31:0] m_data;
    int exp_lat, cyc, re_cnt, re_cyc, vcyc;
    bit done;
    int idx;
    idx = int'(a[2:0]);
    if (fa) model_clear();
    m_hit  = !fa && ref_v[idx] && (ref_tag[idx] == a[7:3]);
    m_data = m_hit ? ref_data[idx] : md;
    if (m_hit) begin
      if (ref_hits < CMAX) ref_hits++;
    end else begin
      ref_v[idx] = 1'b1; ref_tag[idx] = a[7:3]; ref_data[idx] = md;
      if (ref_misses < CMAX) ref_misses++;
      if (fb) model_clear();
    end
    if (use_tbl) begin
      m_hit = t_hit; m_data = t_data;
    end

    check("idle_busy", {63'd0, busy}, 64'd0);
    ce = 1'b1; addr = a; flush = fa;
    cyc = 0; re_cnt = 0; re_cyc = 0; vcyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      mem_valid = 1'b0;
      mem_data = 32'h0;
      if (mem_re) begin
        re_cnt++;
        re_cyc = cyc;
        check("mem_addr", {56'd0, mem_addr}, {56'd0, a});
      end
      if (valid_o) begin
        done = 1'b1;
        vcyc = cyc;
      end else begin
        if (re_cnt > 0 && cyc == re_cyc + lat) begin
          mem_valid = 1'b1;
          mem_data  = md;
        end
        if (fb && re_cnt > 0 && cyc == 2) flush = 1'b1;
      end
    end
    ce = 1'b0; mem_valid = 1'b0; flush = 1'b0;
    exp_lat = m_hit ? 1 : 2 + lat;
    check("resp_seen", {63'd0, done}, 64'd1);
    check("resp_latency", 64'(vcyc), 64'(exp_lat));
    check("resp_data", {32'd0, data_o}, {32'd0, m_data});
    check("mem_re_count", 64'(re_cnt), m_hit ? 64'd0 : 64'd1);
    check("hit_cnt", 64'(hit_cnt), use_tbl ? 64'(t_hits) : 64'(ref_hits));
    check("miss_cnt", 64'(miss_cnt), use_tbl ? 64'(t_misses) : 64'(ref_misses));
    @(negedge clk);
    check("data_hold", {32'd0, data_o}, {32'd0, m_data});
  endtask

  initial begin
    logic [31:0] last;
    int vcount;
    //               addr   md            lat fa fb hit data          h  m
    tbl[0] = '{8'h2A, 32'hDEADBEEF, 3, 0, 0, 0, 32'hDEADBEEF, 0, 1};
    tbl[1] = '{8'h2A, 32'h00000000, 1, 0, 0, 1, 32'hDEADBEEF, 1, 1};
    tbl[2] = '{8'h32, 32'h11111111, 2, 0, 0, 0, 32'h11111111, 1, 2};
    tbl[3] = '{8'h2A, 32'hDEADBEEF, 1, 0, 0, 0, 32'hDEADBEEF, 1, 3};
    tbl[4] = '{8'h05, 32'h55AA55AA, 4, 0, 1, 0, 32'h55AA55AA, 1, 4};
    tbl[5] = '{8'h05, 32'h00000505, 2, 0, 0, 0, 32'h00000505, 1, 5};
    tbl[6] = '{8'h05, 32'h00000000, 1, 0, 0, 1, 32'h00000505, 2, 5};
    tbl[7] = '{8'h2A, 32'hCAFEF00D, 1, 0, 0, 0, 32'hCAFEF00D, 2, 6};
    tbl[8] = '{8'h2A, 32'h12345678, 2, 1, 0, 0, 32'h12345678, 2, 7};
    tbl[9] = '{8'h2A, 32'h00000000, 1, 0, 0, 1, 32'h12345678, 3, 7};

    rst_n = 1'b0; flush = 1'b0; ce = 1'b0; addr = 8'h0;
    mem_data = 32'h0; mem_valid = 1'b0;
    model_clear(); ref_hits = 0; ref_misses = 0;
    repeat (3) @(negedge clk);
    check("rst_data", {32'd0, data_o}, 64'd0);
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_mem_re", {63'd0, mem_re}, 64'd0);
    check("rst_mem_addr", {56'd0, mem_addr}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_cnts", {56'd0, hit_cnt, miss_cnt}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      lookup(tbl[i].addr, tbl[i].md, tbl[i].lat, tbl[i].fa, tbl[i].fb, 1'b1,
             tbl[i].hit, tbl[i].data, tbl[i].hits, tbl[i].misses);

    // Stray memory return while idle must not touch cache or outputs.
    last = data_o;
    mem_valid = 1'b1; mem_data = 32'hFFFFFFFF;
    @(negedge clk);
    mem_valid = 1'b0; mem_data = 32'h0;
    check("stray_idle_valid", {63'd0, valid_o}, 64'd0);
    check("stray_idle_data", {32'd0, data_o}, {32'd0, last});
    check("stray_idle_busy", {63'd0, busy}, 64'd0);
    lookup(8'h2A, 32'h0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);

    // Reset in the middle of a miss, then a late memory return.
    ce = 1'b1; addr = 8'h77;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", {32'd0, data_o}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_mem_addr", {56'd0, mem_addr}, 64'd0);
    check("midrst_cnts", {56'd0, hit_cnt, miss_cnt}, 64'd0);
    ce = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear(); ref_hits = 0; ref_misses = 0;
    @(negedge clk);
    mem_valid = 1'b1; mem_data = 32'hBADBAD00;
    @(negedge clk);
    mem_valid = 1'b0; mem_data = 32'h0;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_o) vcount++;
      @(negedge clk);
    end
    check("postrst_no_valid", 64'(vcount), 64'd0);
    check("postrst_data", {32'd0, data_o}, 64'd0);
    check("postrst_busy", {63'd0, busy}, 64'd0);
    lookup(8'h2A, 32'hA5A5A5A5, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);

    // Randomized traffic over a small address set so hits, conflicts,
    // flushes and counter saturation all occur.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] ra;
      ra = {3'b000, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      lookup(ra, $urandom, int'($urandom_range(1, 5)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             1'b0, 1'b0, 32'h0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
